// File: rtl/ahb_led_pwm_if.sv
// AHB-Lite bus bundle between the RISC-V core's mem_ahb master port and the LED PWM slave.
interface ahb_led_pwm_if;
    logic [1:0]  htrans;
    logic        hready;
    logic        hwrite;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output htrans, hready, hwrite, haddr, hsize, hburst, hwdata,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  htrans, hready, hwrite, haddr, hsize, hburst, hwdata,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_led_pwm.sv
// Zero-wait AHB-Lite slave driving LED_D2/LED_D3 with 8-bit PWM and optional blink gating.
module ahb_led_pwm #(
    parameter logic [31:0] ID_VALUE = 32'h4C45_4431,
    parameter int          PRESC_W  = 16
) (
    input  logic         sys_clock,
    input  logic         resetn,
    ahb_led_pwm_if.slave mem_ahb,
    output logic         LED_D2,
    output logic         LED_D3
);
    logic               dp_valid;
    logic               dp_write;
    logic [2:0]         dp_addr;
    logic [3:0]         dp_strb;
    logic [3:0]         ap_strb;
    logic [31:0]        wmask;
    logic               wr_en;
    logic               presc_wr;

    logic [4:0]         ctrl_r;
    logic [PRESC_W-1:0] presc_r;
    logic [15:0]        duty_r;
    logic [15:0]        blink_r;

    logic [PRESC_W-1:0] presc_cnt;
    logic [7:0]         pwm_cnt;
    logic [15:0]        blink_cnt;
    logic               phase;
    logic               running;
    logic               tick;
    logic               wrap;
    logic               on0;
    logic               on1;
    logic               unused_bits;

    assign mem_ahb.hreadyout = 1'b1;
    assign mem_ahb.hresp     = 1'b0;
    assign unused_bits       = ^{mem_ahb.haddr[31:5], mem_ahb.hburst, mem_ahb.htrans[0]};

    // Byte lanes touched by the transfer; anything wider than a word acts as a word.
    always_comb begin
        case (mem_ahb.hsize)
            3'd0:    ap_strb = 4'b0001 << mem_ahb.haddr[1:0];
            3'd1:    ap_strb = mem_ahb.haddr[1] ? 4'b1100 : 4'b0011;
            default: ap_strb = 4'b1111;
        endcase
    end

    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_strb  <= '0;
        end else begin
            dp_valid <= mem_ahb.hready & mem_ahb.htrans[1];
            dp_write <= mem_ahb.hwrite;
            dp_addr  <= mem_ahb.haddr[4:2];
            dp_strb  <= ap_strb;
        end
    end

    assign wmask    = {{8{dp_strb[3]}}, {8{dp_strb[2]}}, {8{dp_strb[1]}}, {8{dp_strb[0]}}};
    assign wr_en    = dp_valid & dp_write;
    assign presc_wr = wr_en & (dp_addr == 3'd1);

    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            ctrl_r  <= '0;
            presc_r <= '0;
            duty_r  <= '0;
            blink_r <= '0;
        end else if (wr_en) begin
            case (dp_addr)
                3'd0: if (dp_strb[0]) ctrl_r <= mem_ahb.hwdata[4:0];
                3'd1: presc_r <= (presc_r & ~wmask[PRESC_W-1:0])
                               | (mem_ahb.hwdata[PRESC_W-1:0] & wmask[PRESC_W-1:0]);
                3'd2: duty_r  <= (duty_r & ~wmask[15:0]) | (mem_ahb.hwdata[15:0] & wmask[15:0]);
                3'd3: blink_r <= (blink_r & ~wmask[15:0]) | (mem_ahb.hwdata[15:0] & wmask[15:0]);
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_ahb.hrdata = 32'd0;
        if (dp_valid && !dp_write) begin
            case (dp_addr)
                3'd0:    mem_ahb.hrdata = {27'd0, ctrl_r};
                3'd1:    mem_ahb.hrdata = 32'(presc_r);
                3'd2:    mem_ahb.hrdata = {16'd0, duty_r};
                3'd3:    mem_ahb.hrdata = {16'd0, blink_r};
                3'd4:    mem_ahb.hrdata = {23'd0, phase, pwm_cnt};
                3'd5:    mem_ahb.hrdata = ID_VALUE;
                default: mem_ahb.hrdata = 32'd0;
            endcase
        end
    end

    assign running = ctrl_r[0] | ctrl_r[1];
    assign tick    = (presc_cnt == presc_r);
    assign wrap    = tick & (pwm_cnt == 8'hFF);

    // A PRESC write outranks a coincident tick so the time base restarts cleanly.
    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (presc_wr || !running) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
            if (tick)
                pwm_cnt <= pwm_cnt + 8'd1;
            if (wrap) begin
                if (blink_cnt == blink_r) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
        end
    end

    assign on0 = ctrl_r[0] & (pwm_cnt < duty_r[7:0])  & (~ctrl_r[2] | phase);
    assign on1 = ctrl_r[1] & (pwm_cnt < duty_r[15:8]) & (~ctrl_r[3] | phase);

    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            LED_D2 <= 1'b1;
            LED_D3 <= 1'b1;
        end else begin
            LED_D2 <= ctrl_r[4] ? on0 : ~on0;
            LED_D3 <= ctrl_r[4] ? on1 : ~on1;
        end
    end
endmodule

// File: tb/tb_ahb_led_pwm.sv
// Self-checking bench for ahb_led_pwm: table-driven bus vectors with a read scoreboard plus PWM/blink sequences.
module tb_ahb_led_pwm;
    localparam logic [31:0] ID = 32'h4C45_4431;

    typedef struct {
        bit          rdy;
        bit          v;
        bit          w;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic [31:0] mask;
    } sb_t;

    logic        sys_clock = 1'b0;
    logic        resetn;
    logic        LED_D2;
    logic        LED_D3;
    int          checks = 0;
    int          errors = 0;
    bit          prev_read = 1'b0;
    logic [31:0] prev_wdata = 32'd0;
    sb_t         sb_q[$];
    vec_t        vecs[$];

    ahb_led_pwm_if bus();

    ahb_led_pwm #(.ID_VALUE(ID), .PRESC_W(16)) dut (
        .sys_clock(sys_clock),
        .resetn   (resetn),
        .mem_ahb  (bus),
        .LED_D2   (LED_D2),
        .LED_D3   (LED_D3)
    );

    always #5 sys_clock = ~sys_clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: new address phase plus the data phase of the previous beat.
    task automatic applyStimulus(input bit rdy, input bit v, input bit w, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata,
                                 input logic [31:0] exp, input logic [31:0] mask, input string name);
        bus.hready = rdy;
        bus.htrans = v ? 2'b10 : 2'b00;
        bus.hwrite = w;
        bus.haddr  = addr;
        bus.hsize  = size;
        bus.hburst = 3'd0;
        bus.hwdata = prev_wdata;
        @(negedge sys_clock);
        if (prev_read) begin
            if (sb_q.size() == 0) begin
                checkOutput("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                checkOutput(e.name, bus.hrdata & e.mask, e.exp & e.mask);
                checkOutput({e.name, "_hresp"}, 32'(bus.hresp), 32'd0);
            end
        end else begin
            checkOutput("hrdata_no_read", bus.hrdata, 32'd0);
        end
        prev_read = rdy & v & ~w;
        if (prev_read) sb_q.push_back('{name, exp, mask});
        prev_wdata = wdata;
        @(posedge sys_clock);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, 1'b1, addr, 3'd2, data, 32'd0, 32'd0, "wr");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input logic [31:0] mask, input string name);
        applyStimulus(1'b1, 1'b1, 1'b0, addr, 3'd2, 32'd0, exp, mask, name);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 3'd2, 32'd0, 32'd0, 32'd0, "idle");
    endtask

    task automatic sync();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic countLevel(input int n, input bit ch, input bit level, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge sys_clock);
            if ((ch ? LED_D3 : LED_D2) == level) cnt++;
        end
    endtask

    task automatic waitLevelRun(input bit ch, input bit level, input int run, input int limit,
                                output int cycles, output bit found);
        int streak;
        streak = 0;
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < limit) begin
            @(negedge sys_clock);
            cycles++;
            if ((ch ? LED_D3 : LED_D2) == level) streak++;
            else streak = 0;
            if (streak >= run) found = 1'b1;
        end
    endtask

    initial begin
        int  cnt;
        int  cyc;
        bit  found;

        resetn     = 1'b0;
        bus.hready = 1'b1;
        bus.htrans = 2'b00;
        bus.hwrite = 1'b0;
        bus.haddr  = 32'd0;
        bus.hsize  = 3'd2;
        bus.hburst = 3'd0;
        bus.hwdata = 32'd0;
        repeat (3) @(posedge sys_clock);
        @(negedge sys_clock);
        checkOutput("reset_led_d2", 32'(LED_D2), 32'd1);
        checkOutput("reset_led_d3", 32'(LED_D3), 32'd1);
        checkOutput("reset_hreadyout", 32'(bus.hreadyout), 32'd1);
        checkOutput("reset_hrdata", bus.hrdata, 32'd0);
        resetn = 1'b1;
        sync();

        vecs.push_back('{1, 1, 0, 32'h00, 3'd2, 32'h0, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h04, 3'd2, 32'h0, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h08, 3'd2, 32'h0, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h0C, 3'd2, 32'h0, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h10, 3'd2, 32'h0, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h14, 3'd2, 32'h0, ID});
        vecs.push_back('{1, 1, 1, 32'h08, 3'd2, 32'h0000_8040, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h08, 3'd2, 32'h0, 32'h0000_8040});
        vecs.push_back('{1, 1, 1, 32'h09, 3'd0, 32'h0000_AA00, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h08, 3'd2, 32'h0, 32'h0000_AA40});
        vecs.push_back('{1, 1, 1, 32'h0A, 3'd1, 32'h1234_0000, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h08, 3'd2, 32'h0, 32'h0000_AA40});
        vecs.push_back('{1, 1, 1, 32'h1C, 3'd2, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h1C, 3'd2, 32'h0, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h08, 3'd2, 32'h0, 32'h0000_AA40});
        vecs.push_back('{1, 0, 1, 32'h08, 3'd2, 32'h0, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h08, 3'd2, 32'h0, 32'h0000_AA40});
        vecs.push_back('{1, 0, 0, 32'h00, 3'd2, 32'h0, 32'h0});
        vecs.push_back('{0, 1, 1, 32'h08, 3'd2, 32'h0, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h08, 3'd2, 32'h0, 32'h0000_AA40});
        vecs.push_back('{1, 1, 1, 32'h08, 3'd1, 32'hBEEF_1234, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h08, 3'd2, 32'h0, 32'h0000_1234});
        vecs.push_back('{1, 1, 1, 32'h0C, 3'd2, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h0C, 3'd2, 32'h0, 32'h0000_FFFF});
        vecs.push_back('{1, 1, 1, 32'h04, 3'd3, 32'h0000_0005, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h04, 3'd2, 32'h0, 32'h0000_0005});
        vecs.push_back('{1, 1, 1, 32'h05, 3'd0, 32'h0000_FF00, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h04, 3'd2, 32'h0, 32'h0000_FF05});
        vecs.push_back('{1, 1, 1, 32'h04, 3'd2, 32'h0, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h04, 3'd2, 32'h0, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h10, 3'd2, 32'h0, 32'h0});
        vecs.push_back('{1, 1, 0, 32'h00, 3'd2, 32'h0, 32'h0});
        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i].rdy, vecs[i].v, vecs[i].w, vecs[i].addr, vecs[i].size,
                          vecs[i].wdata, vecs[i].exp, 32'hFFFF_FFFF, $sformatf("vec%0d", i));
        idle();
        idle();

        $display("[TB] PWM sequence");
        wr(32'h08, 32'h0000_0040);
        wr(32'h04, 32'h0);
        wr(32'h00, 32'h01);
        idle();
        idle();
        countLevel(10, 1'b0, 1'b0, cnt);
        countLevel(256, 1'b0, 1'b0, cnt);
        checkOutput("pwm_d2_low_window0", cnt, 64);
        countLevel(256, 1'b0, 1'b0, cnt);
        checkOutput("pwm_d2_low_window1", cnt, 64);
        countLevel(512, 1'b1, 1'b0, cnt);
        checkOutput("pwm_d3_stays_high", cnt, 0);
        sync();
        wr(32'h00, 32'h11);
        idle();
        idle();
        countLevel(10, 1'b0, 1'b1, cnt);
        countLevel(256, 1'b0, 1'b1, cnt);
        checkOutput("pwm_d2_high_pol", cnt, 64);

        $display("[TB] blink sequence");
        sync();
        wr(32'h00, 32'h0);
        wr(32'h08, 32'h0000_FF40);
        wr(32'h0C, 32'h1);
        wr(32'h04, 32'h3);
        wr(32'h00, 32'h0A);
        idle();
        waitLevelRun(1'b1, 1'b0, 1, 3000, cyc, found);
        checkOutput("blink_onset_found", 32'(found), 32'd1);
        checkOutput("blink_onset_near_2048", 32'(cyc >= 2040 && cyc <= 2060), 32'd1);
        sync();
        rd(32'h10, 32'h100, 32'h100, "status_phase1");
        idle();
        waitLevelRun(1'b1, 1'b1, 16, 2300, cyc, found);
        checkOutput("blink_gate_found", 32'(found), 32'd1);
        sync();
        rd(32'h10, 32'h000, 32'h100, "status_phase0");
        idle();
        countLevel(1000, 1'b1, 1'b0, cnt);
        checkOutput("blink_gated_off", cnt, 0);
        waitLevelRun(1'b1, 1'b0, 1, 1300, cyc, found);
        checkOutput("blink_reonset_found", 32'(found), 32'd1);
        countLevel(2047, 1'b1, 1'b0, cnt);
        checkOutput("blink_active_lows", cnt + 1, 2040);

        $display("[TB] counter clears");
        sync();
        wr(32'h04, 32'h3);
        rd(32'h10, 32'h0, 32'hFFFF_FFFF, "status_after_presc_write");
        idle();
        wr(32'h00, 32'h0);
        idle();
        idle();
        rd(32'h10, 32'h0, 32'hFFFF_FFFF, "status_disabled");
        idle();
        countLevel(50, 1'b0, 1'b0, cnt);
        checkOutput("disabled_d2_off", cnt, 0);
        countLevel(50, 1'b1, 1'b0, cnt);
        checkOutput("disabled_d3_off", cnt, 0);
        sync();
        rd(32'h10, 32'h0, 32'hFFFF_FFFF, "status_still_frozen");
        idle();

        $display("[TB] reset mid-transfer");
        wr(32'h00, 32'h03);
        idle();
        repeat (40) @(posedge sys_clock);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h08, 3'd2, 32'h0000_FFFF, 32'd0, 32'd0, "wr_abort");
        bus.htrans = 2'b00;
        bus.hwdata = 32'h0000_FFFF;
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("midreset_led_d2", 32'(LED_D2), 32'd1);
        checkOutput("midreset_led_d3", 32'(LED_D3), 32'd1);
        checkOutput("midreset_hreadyout", 32'(bus.hreadyout), 32'd1);
        checkOutput("midreset_hrdata", bus.hrdata, 32'd0);
        prev_read  = 1'b0;
        prev_wdata = 32'd0;
        repeat (2) @(negedge sys_clock);
        resetn = 1'b1;
        sync();
        for (int a = 0; a < 6; a++)
            rd(32'(a * 4), (a == 5) ? ID : 32'd0, 32'hFFFF_FFFF, $sformatf("post_reset_reg%0d", a));
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
